float_copro_seq: RTL and testbench

- Command sequencer and operand/result buffer for the floating-point coprocessor.
- Sits between the LM32 custom-instruction/bus glue (upstream) and the float_pack arithmetic (float_add, float_sub, float_mul).
- Registers operands, invokes one arithmetic function per compute cycle, owns a float accumulator for multiply-accumulate, and holds each result until the CPU side takes it.

---
 rtl/float_pack.sv | 99 +++++++++
 rtl/float_copro_acc.sv | 24 ++
 rtl/float_copro_seq.sv | 139 +++++++++++++
 tb/tb_float_copro_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/float_pack.sv
// Single-precision float type and truncating arithmetic used by the coprocessor datapath,
// plus the sequencer's opcode set and zero helpers.
package float_pack;
  localparam int NE   = 8;
  localparam int NM   = 23;
  localparam int FW   = 1 + NE + NM;
  localparam int BIAS = (1 << (NE - 1)) - 1;

  typedef logic [FW-1:0] float;

  localparam float FLOAT_ZERO = '0;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_ACC_LD, OP_ACC_RD, OP_ACC_CLR, OP_RSVD
  } copro_op_t;

  // Denormals are flushed, so any zero exponent counts as zero.
  function automatic logic float_is_zero(input float f);
    return f[FW-2:NM] == '0;
  endfunction

  function automatic float float_add(input float a, input float b);
    float          r;
    logic          sx, sy;
    logic [NE-1:0] ex, ey;
    logic [NM+1:0] mx, my, m;
    logic [NE:0]   e;
    r = FLOAT_ZERO;
    if (float_is_zero(a)) begin
      r = b;
    end else if (float_is_zero(b)) begin
      r = a;
    end else begin
      // Order by magnitude so the subtraction never goes negative.
      if (a[FW-2:0] >= b[FW-2:0]) begin
        sx = a[FW-1]; ex = a[FW-2:NM]; mx = {2'b01, a[NM-1:0]};
        sy = b[FW-1]; ey = b[FW-2:NM]; my = {2'b01, b[NM-1:0]};
      end else begin
        sx = b[FW-1]; ex = b[FW-2:NM]; mx = {2'b01, b[NM-1:0]};
        sy = a[FW-1]; ey = a[FW-2:NM]; my = {2'b01, a[NM-1:0]};
      end
      my = my >> (ex - ey);
      e  = {1'b0, ex};
      if (sx == sy) begin
        m = mx + my;
        if (m[NM+1]) begin
          m = m >> 1;
          e = e + (NE+1)'(1);
        end
      end else begin
        m = mx - my;
        for (int i = 0; i < NM + 1; i++) begin
          if (!m[NM] && e > (NE+1)'(1)) begin
            m = m << 1;
            e = e - (NE+1)'(1);
          end
        end
      end
      if (m == '0 || !m[NM])
        r = FLOAT_ZERO;
      else if (e >= (NE+1)'((1 << NE) - 1))
        r = {sx, {NE{1'b1}}, {NM{1'b0}}};
      else
        r = {sx, e[NE-1:0], m[NM-1:0]};
    end
    return r;
  endfunction

  function automatic float float_sub(input float a, input float b);
    return float_add(a, {~b[FW-1], b[FW-2:0]});
  endfunction

  function automatic float float_mul(input float a, input float b);
    float              r;
    logic              s;
    logic [2*NM+1:0]   p;
    logic [NM-1:0]     m;
    int                e;
    r = FLOAT_ZERO;
    s = a[FW-1] ^ b[FW-1];
    if (!float_is_zero(a) && !float_is_zero(b)) begin
      p = {{(NM+1){1'b0}}, 1'b1, a[NM-1:0]} * {{(NM+1){1'b0}}, 1'b1, b[NM-1:0]};
      e = int'(a[FW-2:NM]) + int'(b[FW-2:NM]) - BIAS;
      if (p[2*NM+1]) begin
        m = p[2*NM:NM+1];
        e = e + 1;
      end else begin
        m = p[2*NM-1:NM];
      end
      if (e <= 0)
        r = FLOAT_ZERO;
      else if (e >= (1 << NE) - 1)
        r = {s, {NE{1'b1}}, {NM{1'b0}}};
      else
        r = {s, NE'(e), m};
    end
    return r;
  endfunction
endpackage

// File: rtl/float_copro_acc.sv
// Float accumulator register; clear has priority over load.
module float_copro_acc
  import float_pack::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic ld,
  input  logic clr,
  input  float d,
  output float q
);
  float acc_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      acc_reg <= FLOAT_ZERO;
    else if (clr)
      acc_reg <= FLOAT_ZERO;
    else if (ld)
      acc_reg <= d;
  end

  assign q = acc_reg;
endmodule

// File: rtl/float_copro_seq.sv
// Command sequencer for the float coprocessor: latches one command, runs it through
// the float_pack arithmetic, and holds the result until the CPU side consumes it.
module float_copro_seq
  import float_pack::*;
#(
  parameter int OP_W   = 3,
  parameter bit MAC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  float            cmd_a,
  input  float            cmd_b,
  output logic            res_valid,
  input  logic            res_ready,
  output float            res_data,
  output logic            res_err,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, EXEC, MAC_ADD, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [OP_W-1:0] op_reg, op_next;
  float            a_reg, a_next, b_reg, b_next, t_reg, t_next;
  float            res_reg, res_next;
  logic            err_reg, err_next, valid_reg, valid_next;
  logic            acc_ld, acc_clr;
  float            acc_d, acc_q;

  float_copro_acc u_acc (
    .clk  (clk),
    .nrst (nrst),
    .ld   (acc_ld),
    .clr  (acc_clr),
    .d    (acc_d),
    .q    (acc_q)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      a_reg     <= FLOAT_ZERO;
      b_reg     <= FLOAT_ZERO;
      t_reg     <= FLOAT_ZERO;
      res_reg   <= FLOAT_ZERO;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      t_reg     <= t_next;
      res_reg   <= res_next;
      err_reg   <= err_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    t_next     = t_reg;
    res_next   = res_reg;
    err_next   = err_reg;
    valid_next = valid_reg;
    acc_ld     = 1'b0;
    acc_clr    = 1'b0;
    acc_d      = float_add(acc_q, t_reg);
    unique case (state_reg)
      IDLE: if (cmd_valid) begin
        op_next    = cmd_op;
        a_next     = cmd_a;
        b_next     = cmd_b;
        state_next = EXEC;
      end
      EXEC: begin
        err_next   = 1'b0;
        state_next = HOLD;
        case (op_reg)
          OP_W'(OP_ADD):     res_next = float_add(a_reg, b_reg);
          OP_W'(OP_SUB):     res_next = float_sub(a_reg, b_reg);
          OP_W'(OP_MUL):     res_next = float_mul(a_reg, b_reg);
          OP_W'(OP_MAC): begin
            if (MAC_EN) begin
              t_next     = float_mul(a_reg, b_reg);
              state_next = MAC_ADD;
            end else begin
              res_next = FLOAT_ZERO;
              err_next = 1'b1;
            end
          end
          OP_W'(OP_ACC_LD): begin
            acc_ld   = 1'b1;
            acc_d    = a_reg;
            res_next = a_reg;
          end
          OP_W'(OP_ACC_RD):  res_next = acc_q;
          OP_W'(OP_ACC_CLR): begin
            acc_clr  = 1'b1;
            res_next = FLOAT_ZERO;
          end
          default: begin
            res_next = FLOAT_ZERO;
            err_next = 1'b1;
          end
        endcase
      end
      MAC_ADD: begin
        acc_ld     = 1'b1;
        res_next   = acc_d;
        err_next   = 1'b0;
        state_next = HOLD;
      end
      HOLD: begin
        // The valid flag is raised one cycle after entering HOLD so the output
        // stage is fed purely from registers, never straight from the arithmetic.
        if (!valid_reg) begin
          valid_next = 1'b1;
        end else if (res_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign res_valid = valid_reg;
  assign res_data  = res_reg;
  assign res_err   = err_reg;
endmodule

// File: tb/tb_float_copro_seq.sv
// Directed bench for float_copro_seq: one MAC-enabled unit and one MAC-disabled unit,
// expected results queued at issue and checked when each result appears.
module tb_float_copro_seq;
  import float_pack::*;

  typedef struct {
    float d;
    logic e;
    int   lat;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [2:0] cmd_op = '0;
  float       cmd_a = '0, cmd_b = '0;
  logic       cmd_valid [2];
  logic       res_ready [2];
  logic       cmd_ready [2];
  logic       res_valid [2];
  logic       res_err   [2];
  logic       busy      [2];
  float       res_data  [2];
  sb_item_t   sb_q[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  float_copro_seq #(.OP_W(3), .MAC_EN(1'b1)) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .res_err(res_err[0]), .busy(busy[0])
  );

  float_copro_seq #(.OP_W(3), .MAC_EN(1'b0)) dut_nomac (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .res_err(res_err[1]), .busy(busy[1])
  );

  task automatic chk(input logic [31:0] got, input logic [31:0] want, input string tag);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic run_cmd(input int u, input logic [2:0] op, input float a, input float b,
                         input float exp_d, input logic exp_e, input int lat, input string tag);
    sb_item_t it;
    int       cnt;
    sb_q.push_back('{exp_d, exp_e, lat});
    @(negedge clk);
    chk(32'(cmd_ready[u]), 32'd1, {tag, ".ready"});
    cmd_valid[u] = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid[u] = 1'b0;
    cnt = 0;
    while (res_valid[u] !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    it = sb_q.pop_front();
    chk(32'(cnt), 32'(it.lat), {tag, ".latency"});
    chk(res_data[u], it.d, {tag, ".data"});
    chk(32'(res_err[u]), 32'(it.e), {tag, ".err"});
    $display("txn %s unit=%0d op=%0d data=%h err=%b lat=%0d",
             tag, u, op, res_data[u], res_err[u], cnt);
    if (res_ready[u]) begin
      @(posedge clk); #1;
      chk(32'({res_valid[u], cmd_ready[u]}), 32'b01, {tag, ".consumed"});
    end
  endtask

  initial begin
    cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
    res_ready[0] = 1'b1; res_ready[1] = 1'b1;

    // Reset state
    #12;
    chk(32'(res_valid[0]), 32'd0, "rst.valid");
    chk(res_data[0], 32'h0, "rst.data");
    chk(32'(res_err[0]), 32'd0, "rst.err");
    chk(32'(busy[0]), 32'd0, "rst.busy");
    @(negedge clk); nrst = 1'b1;
    #1 chk(32'(cmd_ready[0]), 32'd1, "rst.ready");

    run_cmd(0, OP_ADD, 32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0, 2, "add");
    run_cmd(0, OP_SUB, 32'h40700000, 32'h3FC00000, 32'h40100000, 1'b0, 2, "sub");
    run_cmd(0, OP_SUB, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 1'b0, 2, "sub_zero");
    run_cmd(0, OP_MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 2, "mul");

    // 1.5*2 accumulated twice from +0 gives 6.0
    run_cmd(0, OP_ACC_CLR, 32'h0, 32'h0, 32'h00000000, 1'b0, 2, "acc_clr");
    run_cmd(0, OP_MAC, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 3, "mac1");
    run_cmd(0, OP_MAC, 32'h3FC00000, 32'h40000000, 32'h40C00000, 1'b0, 3, "mac2");
    run_cmd(0, OP_ACC_RD, 32'h0, 32'h0, 32'h40C00000, 1'b0, 2, "acc_rd");

    // Backpressure: held result, ignored ACC_CLR pulse
    res_ready[0] = 1'b0;
    run_cmd(0, OP_ADD, 32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0, 2, "bp_add");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid[0] = (i == 3); cmd_op = OP_ACC_CLR;
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      chk(32'({res_valid[0], cmd_ready[0], busy[0]}), 32'b101, "bp.flags");
      chk(res_data[0], 32'h40700000, "bp.data");
    end
    @(negedge clk); res_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk(32'(res_valid[0]), 32'd0, "bp.release");
    run_cmd(0, OP_ACC_RD, 32'h0, 32'h0, 32'h40C00000, 1'b0, 2, "bp_acc_rd");
    run_cmd(0, OP_ADD, 32'h40700000, 32'h3FC00000, 32'h40A80000, 1'b0, 2, "add_keeps_acc");
    run_cmd(0, OP_ACC_RD, 32'h0, 32'h0, 32'h40C00000, 1'b0, 2, "acc_rd2");

    // Illegal opcodes
    run_cmd(0, OP_RSVD, 32'h3FC00000, 32'h40100000, 32'h00000000, 1'b1, 2, "op7");
    run_cmd(1, OP_ACC_LD, 32'h3FC00000, 32'h0, 32'h3FC00000, 1'b0, 2, "nomac_ld");
    run_cmd(1, OP_MAC, 32'h3FC00000, 32'h40000000, 32'h00000000, 1'b1, 2, "nomac_mac");
    run_cmd(1, OP_ACC_RD, 32'h0, 32'h0, 32'h3FC00000, 1'b0, 2, "nomac_rd");

    // Asynchronous reset while the MAC is in its accumulate step
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_op = OP_MAC; cmd_a = 32'h3FC00000; cmd_b = 32'h40000000;
    @(posedge clk); #1 cmd_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk(32'(busy[0]), 32'd1, "midrst.busy_before");
    #2 nrst = 1'b0;
    #1;
    chk(32'({res_valid[0], busy[0]}), 32'b00, "midrst.async");
    @(negedge clk); nrst = 1'b1;
    #1 chk(32'(cmd_ready[0]), 32'd1, "midrst.ready");
    run_cmd(0, OP_ACC_RD, 32'h0, 32'h0, 32'h00000000, 1'b0, 2, "midrst_acc_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
